// File: rtl/cpu_pkg.sv
// Shared CPU types for the flag hazard/forwarding pipe.
// A flag slot records one in-flight instruction's carry/zero update as it
// moves from MEM to WB.
package cpu_pkg;

   // One pipeline slot of pending flag updates.
   //   valid : slot holds a real (non-squashed) instruction
   //   cwr   : instruction writes carry
   //   zwr   : instruction writes zero
   //   c, z  : values to be written
   //   ldz   : zero comes from load data, resolved while the slot is in MEM
   typedef struct packed {
      logic valid;
      logic cwr;
      logic zwr;
      logic c;
      logic z;
      logic ldz;
   } flag_slot_t;

   // Flag indices used for the per-flag forwarding vectors.
   localparam int FLAG_C    = 0;
   localparam int FLAG_Z    = 1;
   localparam int NUM_FLAGS = 2;

endpackage

// File: rtl/flag_fwd_mux.sv
// Per-flag forwarding selector: youngest pending writer wins, falling back
// to the architectural flag. With FWD_EN = 0 the architectural flag is
// always selected (debug mode).
module flag_fwd_mux #(
   parameter bit FWD_EN = 1'b1
) (
   input  logic mem_hit,
   input  logic mem_val,
   input  logic wb_hit,
   input  logic wb_val,
   input  logic arch_val,
   output logic fwd_val
);

   // Priority select: MEM slot, then WB slot, then architectural value.
   always_comb begin
      fwd_val = arch_val;
      if (FWD_EN) begin
         if (mem_hit) begin
            fwd_val = mem_val;
         end else if (wb_hit) begin
            fwd_val = wb_val;
         end
      end
   end

endmodule

// File: rtl/flag_hazard_pipe.sv
// Tracks carry/zero updates in flight through MEM and WB, forwards the
// youngest pending values to the EX condition logic, and drives the flag
// register commit port from the WB slot.
//
// Handshake: there is no valid/ready pair here; the pipe advances on every
// clock unless stall is high. flush squashes the EX capture and the MEM slot
// and takes priority over stall. Commit strobes are suppressed while stall or
// rst is high, so every valid WB entry commits exactly once.
module flag_hazard_pipe import cpu_pkg::*; #(
   parameter bit FWD_EN = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic stall,
   input  logic flush,
   input  logic ex_valid,
   input  logic ex_carry_wr,
   input  logic ex_zero_wr,
   input  logic ex_carry,
   input  logic ex_zero,
   input  logic ex_zero_from_load,
   input  logic mem_load_zero,
   input  logic arch_carry,
   input  logic arch_zero,
   output logic fwd_carry,
   output logic fwd_zero,
   output logic carry_in,
   output logic zero_in,
   output logic carry_wr,
   output logic zero_wr
);

   flag_slot_t mem_q, mem_d;
   flag_slot_t wb_q,  wb_d;

   logic [NUM_FLAGS-1:0] mem_hit;
   logic [NUM_FLAGS-1:0] mem_val;
   logic [NUM_FLAGS-1:0] wb_hit;
   logic [NUM_FLAGS-1:0] wb_val;
   logic [NUM_FLAGS-1:0] arch_val;
   logic [NUM_FLAGS-1:0] fwd_val;

   // The load-zero marker has already been resolved by the time a slot sits
   // in WB, so the WB copy of it is never consulted.
   logic unused_wb_ldz;
   assign unused_wb_ldz = wb_q.ldz;

   // Next-slot logic: advance EX->MEM->WB, resolving load zero on the way
   // into WB; on stall only a flush may touch MEM (clearing its valid).
   always_comb begin
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!stall) begin
         mem_d.valid = ex_valid & ~flush;
         mem_d.cwr   = ex_carry_wr;
         mem_d.zwr   = ex_zero_wr;
         mem_d.c     = ex_carry;
         mem_d.z     = ex_zero;
         mem_d.ldz   = ex_zero_from_load;
         wb_d        = mem_q;
         if (mem_q.ldz) begin
            wb_d.z = mem_load_zero;
         end
         if (flush) begin
            wb_d.valid = 1'b0;
         end
      end else if (flush) begin
         mem_d.valid = 1'b0;
      end
   end

   // Slot registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   // Per-flag hit/value vectors feeding the forwarding selectors. The MEM
   // zero of a load is the live load-data zero, not the captured ALU zero.
   always_comb begin
      mem_hit           = '0;
      mem_val           = '0;
      wb_hit            = '0;
      wb_val            = '0;
      arch_val          = '0;
      mem_hit[FLAG_C]   = mem_q.valid & mem_q.cwr;
      mem_val[FLAG_C]   = mem_q.c;
      mem_hit[FLAG_Z]   = mem_q.valid & mem_q.zwr;
      mem_val[FLAG_Z]   = mem_q.ldz ? mem_load_zero : mem_q.z;
      wb_hit[FLAG_C]    = wb_q.valid & wb_q.cwr;
      wb_val[FLAG_C]    = wb_q.c;
      wb_hit[FLAG_Z]    = wb_q.valid & wb_q.zwr;
      wb_val[FLAG_Z]    = wb_q.z;
      arch_val[FLAG_C]  = arch_carry;
      arch_val[FLAG_Z]  = arch_zero;
   end

   for (genvar f = 0; f < NUM_FLAGS; f++) begin : g_flag
      flag_fwd_mux #(
         .FWD_EN   (FWD_EN)
      ) u_fwd (
         .mem_hit  (mem_hit[f]),
         .mem_val  (mem_val[f]),
         .wb_hit   (wb_hit[f]),
         .wb_val   (wb_val[f]),
         .arch_val (arch_val[f]),
         .fwd_val  (fwd_val[f])
      );
   end

   assign fwd_carry = fwd_val[FLAG_C];
   assign fwd_zero  = fwd_val[FLAG_Z];

   // Commit port: write strobes from WB, gated off by stall and reset.
   always_comb begin
      carry_wr = wb_q.valid & wb_q.cwr & ~stall & ~rst;
      zero_wr  = wb_q.valid & wb_q.zwr & ~stall & ~rst;
      carry_in = wb_q.c;
      zero_in  = wb_q.z;
   end

endmodule

// File: tb/tb_flag_hazard_pipe.sv
// Bench for flag_hazard_pipe. The bench plays the flag register: arch_carry
// and arch_zero follow a behavioural model of committed instructions.
module tb_flag_hazard_pipe;

   logic clk = 1'b0;
   logic rst, stall, flush;
   logic ex_valid, ex_carry_wr, ex_zero_wr, ex_carry, ex_zero, ex_zero_from_load;
   logic mem_load_zero, arch_carry, arch_zero;
   logic fwd_carry, fwd_zero, carry_in, zero_in, carry_wr, zero_wr;

   int checks   = 0;
   int failures = 0;

   // Reference model: in-flight instructions, youngest first (index 0 is the
   // one that left EX most recently, index 1 the next to retire).
   typedef struct packed {
      logic valid, cwr, zwr, c, z, ldz;
   } instr_t;
   instr_t inflight[$];
   logic   m_arch_c, m_arch_z;
   logic   e_fc, e_fz, e_cw, e_zw, e_ci, e_zi;

   flag_hazard_pipe #(
      .FWD_EN            (1'b1)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .stall             (stall),
      .flush             (flush),
      .ex_valid          (ex_valid),
      .ex_carry_wr       (ex_carry_wr),
      .ex_zero_wr        (ex_zero_wr),
      .ex_carry          (ex_carry),
      .ex_zero           (ex_zero),
      .ex_zero_from_load (ex_zero_from_load),
      .mem_load_zero     (mem_load_zero),
      .arch_carry        (arch_carry),
      .arch_zero         (arch_zero),
      .fwd_carry         (fwd_carry),
      .fwd_zero          (fwd_zero),
      .carry_in          (carry_in),
      .zero_in           (zero_in),
      .carry_wr          (carry_wr),
      .zero_wr           (zero_wr)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- model ----------------
   // Expected outputs: the oldest pending instruction commits; forwarded flag
   // is the value of the youngest in-flight writer of that flag, else arch.
   task automatic model_expect();
      instr_t oldest;
      oldest = inflight[1];
      e_cw = oldest.valid && oldest.cwr && !stall && !rst;
      e_zw = oldest.valid && oldest.zwr && !stall && !rst;
      e_ci = oldest.c;
      e_zi = oldest.z;
      e_fc = m_arch_c;
      e_fz = m_arch_z;
      for (int age = 1; age >= 0; age--) begin
         instr_t e;
         e = inflight[age];
         if (e.valid && e.cwr) e_fc = e.c;
         if (e.valid && e.zwr) e_fz = e.ldz ? mem_load_zero : e.z;
      end
   endtask

   // Advance the model across one clock edge using the pre-edge inputs.
   task automatic model_edge();
      instr_t oldest, moved, fresh;
      if (rst) begin
         inflight = '{instr_t'(0), instr_t'(0)};
         m_arch_c = 1'b0;
         m_arch_z = 1'b0;
      end else begin
         oldest = inflight[1];
         if (oldest.valid && oldest.cwr && !stall) m_arch_c = oldest.c;
         if (oldest.valid && oldest.zwr && !stall) m_arch_z = oldest.z;
         moved = inflight[0];
         if (stall) begin
            if (flush) moved.valid = 1'b0;
            inflight = '{moved, oldest};
         end else begin
            if (moved.ldz) begin
               moved.z   = mem_load_zero;
               moved.ldz = 1'b0;
            end
            if (flush) moved.valid = 1'b0;
            fresh = '{valid: ex_valid && !flush, cwr: ex_carry_wr, zwr: ex_zero_wr,
                      c: ex_carry, z: ex_zero, ldz: ex_zero_from_load};
            inflight = '{fresh, moved};
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      ex_valid = 1'b0; ex_carry_wr = 1'b0; ex_zero_wr = 1'b0;
      ex_carry = 1'b0; ex_zero = 1'b0; ex_zero_from_load = 1'b0;
      mem_load_zero = 1'b0;
   endtask

   task automatic drive_ex(input logic v, input logic cwr, input logic zwr,
                           input logic c, input logic z, input logic ldz);
      ex_valid = v; ex_carry_wr = cwr; ex_zero_wr = zwr;
      ex_carry = c; ex_zero = z; ex_zero_from_load = ldz;
   endtask

   // Move to the sampling point (falling edge) and compute expectations.
   task automatic settle();
      @(negedge clk);
      model_expect();
   endtask

   // Take a rising edge, update the model, then present the new arch flags.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      arch_carry = m_arch_c;
      arch_zero  = m_arch_z;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      set_idle();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_ex(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
         settle();
         checks++;
         if ({carry_wr, zero_wr} !== 2'b00) begin
            failures++;
            $display("FAIL reset_commit: got %b expected 00", {carry_wr, zero_wr});
         end
         tick();
      end
      set_idle();
      for (int i = 0; i < 5; i++) begin
         settle();
         checks++;
         if ({carry_wr, zero_wr, carry_in, zero_in, fwd_carry, fwd_zero} !== 6'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got %b expected 000000",
                     {carry_wr, zero_wr, carry_in, zero_in, fwd_carry, fwd_zero});
         end
         tick();
      end
      // Writer reaches WB, then reset arrives: no commit, slots cleared.
      drive_ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      set_idle();
      tick();
      rst = 1'b1;
      settle();
      checks++;
      if ({carry_wr, zero_wr} !== 2'b00) begin
         failures++;
         $display("FAIL reset_mid_commit: got %b expected 00", {carry_wr, zero_wr});
      end
      tick();
      rst = 1'b0;
      settle();
      checks++;
      if ({fwd_carry, fwd_zero, carry_wr, zero_wr} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_mid_clear: got %b expected 0000",
                  {fwd_carry, fwd_zero, carry_wr, zero_wr});
      end
      tick();
   endtask

   task automatic test_carry_fwd();
      set_idle();
      drive_ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      settle();
      checks++;
      if ({fwd_carry, fwd_zero} !== 2'b10) begin
         failures++;
         $display("FAIL carry_fwd_mem: got %b expected 10", {fwd_carry, fwd_zero});
      end
      tick();
      set_idle();
      settle();
      checks++;
      if ({carry_wr, carry_in, zero_wr, zero_in} !== 4'b1110) begin
         failures++;
         $display("FAIL carry_commit: got %b expected 1110",
                  {carry_wr, carry_in, zero_wr, zero_in});
      end
      tick();
      settle();
      checks++;
      if ({carry_wr, fwd_carry} !== 2'b01) begin
         failures++;
         $display("FAIL carry_after_commit: got %b expected 01", {carry_wr, fwd_carry});
      end
      tick();
   endtask

   task automatic test_back_to_back();
      set_idle();
      drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      set_idle();
      settle();
      checks++;
      if ({fwd_carry, carry_wr, carry_in} !== 3'b011) begin
         failures++;
         $display("FAIL b2b_first: got %b expected 011", {fwd_carry, carry_wr, carry_in});
      end
      tick();
      settle();
      checks++;
      if ({fwd_carry, carry_wr, carry_in} !== 3'b010) begin
         failures++;
         $display("FAIL b2b_second: got %b expected 010", {fwd_carry, carry_wr, carry_in});
      end
      tick();
      // Zero-only writer then carry-only writer: the younger must not mask
      // the older's zero.
      drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      set_idle();
      settle();
      checks++;
      if ({fwd_carry, fwd_zero} !== 2'b11) begin
         failures++;
         $display("FAIL no_mask: got %b expected 11", {fwd_carry, fwd_zero});
      end
      repeat (3) tick();
   endtask

   task automatic test_load_zero();
      set_idle();
      drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      set_idle();
      mem_load_zero = 1'b1;
      settle();
      checks++;
      if (fwd_zero !== 1'b1) begin
         failures++;
         $display("FAIL load_zero_fwd: got %b expected 1", fwd_zero);
      end
      tick();
      mem_load_zero = 1'b0;
      settle();
      checks++;
      if ({zero_wr, zero_in, fwd_zero} !== 3'b111) begin
         failures++;
         $display("FAIL load_zero_commit: got %b expected 111", {zero_wr, zero_in, fwd_zero});
      end
      repeat (2) tick();
   endtask

   task automatic test_flush();
      // arch carry = 1 and arch zero = 1 at this point.
      set_idle();
      drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      flush = 1'b1;
      tick();
      set_idle();
      settle();
      checks++;
      if ({fwd_carry, fwd_zero} !== 2'b11) begin
         failures++;
         $display("FAIL flush_ex_fwd: got %b expected 11", {fwd_carry, fwd_zero});
      end
      tick();
      settle();
      checks++;
      if ({carry_wr, zero_wr, fwd_carry} !== 3'b001) begin
         failures++;
         $display("FAIL flush_ex_commit: got %b expected 001", {carry_wr, zero_wr, fwd_carry});
      end
      tick();
      // Writer already in MEM when the flush arrives.
      drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      set_idle();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      settle();
      checks++;
      if ({carry_wr, fwd_carry} !== 2'b01) begin
         failures++;
         $display("FAIL flush_mem: got %b expected 01", {carry_wr, fwd_carry});
      end
      tick();
      // Stall and flush together: MEM is squashed anyway.
      drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      set_idle();
      stall = 1'b1;
      flush = 1'b1;
      tick();
      set_idle();
      settle();
      checks++;
      if (fwd_carry !== 1'b1) begin
         failures++;
         $display("FAIL stall_flush_fwd: got %b expected 1", fwd_carry);
      end
      tick();
      settle();
      checks++;
      if (carry_wr !== 1'b0) begin
         failures++;
         $display("FAIL stall_flush_commit: got %b expected 0", carry_wr);
      end
      tick();
   endtask

   task automatic test_stall();
      int pulses;
      set_idle();
      drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      set_idle();
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++;
         if ({carry_wr, fwd_carry, carry_in} !== 3'b000) begin
            failures++;
            $display("FAIL stall_hold: cycle %0d got %b expected 000", i,
                     {carry_wr, fwd_carry, carry_in});
         end
         tick();
      end
      stall = 1'b0;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         settle();
         if (carry_wr === 1'b1) pulses++;
         tick();
      end
      checks++;
      if (pulses != 1) begin
         failures++;
         $display("FAIL stall_release_pulses: got %0d expected 1", pulses);
      end
      settle();
      checks++;
      if (fwd_carry !== 1'b0) begin
         failures++;
         $display("FAIL stall_arch_after: got %b expected 0", fwd_carry);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst   = ($urandom_range(0, 39) == 0);
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 7) == 0);
         drive_ex(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
         mem_load_zero = 1'($urandom_range(0, 1));
         settle();
         checks++;
         if ({fwd_carry, fwd_zero, carry_wr, zero_wr, carry_in, zero_in} !==
             {e_fc, e_fz, e_cw, e_zw, e_ci, e_zi}) begin
            failures++;
            $display("FAIL random cycle %0d: got fc,fz,cw,zw,ci,zi=%b expected %b", i,
                     {fwd_carry, fwd_zero, carry_wr, zero_wr, carry_in, zero_in},
                     {e_fc, e_fz, e_cw, e_zw, e_ci, e_zi});
         end
         tick();
      end
      set_idle();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      set_idle();
      rst        = 1'b1;
      inflight   = '{instr_t'(0), instr_t'(0)};
      m_arch_c   = 1'b0;
      m_arch_z   = 1'b0;
      arch_carry = 1'b0;
      arch_zero  = 1'b0;
      tick();
      test_reset();
      test_carry_fwd();
      test_back_to_back();
      test_load_zero();
      test_flush();
      test_stall();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/flag_hazard_pipe.md
Name: flag_hazard_pipe

Overview:
- Tracks in-flight carry/zero flag updates from EX through MEM and WB.
- Forwards the youngest pending flag values to the conditional-execution logic in EX, so conditional ops see correct flags without stalling.
- Drives the commit side of the flag register (carry_in, zero_in, carry_wr, zero_wr) from the WB slot.
- Sits between the EX-stage ALU/condition logic and the flag register.

Parameters:
- FWD_EN, 1, 1 = forwarding active; 0 = fwd outputs always equal the architectural flags (debug mode).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- stall  input  1  pipeline freeze; hold all slots
- flush  input  1  squash the EX capture and the MEM slot (branch/jump redirect)
- ex_valid  input  1  EX instruction valid
- ex_carry_wr  input  1  EX instruction writes carry
- ex_zero_wr  input  1  EX instruction writes zero
- ex_carry  input  1  ALU carry result
- ex_zero  input  1  ALU zero result
- ex_zero_from_load  input  1  EX instruction is a load; zero is resolved in MEM
- mem_load_zero  input  1  zero of load data, valid in MEM
- arch_carry  input  1  flag register carry_flag_status
- arch_zero  input  1  flag register zero_flag_status
- fwd_carry  output  1  effective carry seen by the EX instruction
- fwd_zero  output  1  effective zero seen by the EX instruction
- carry_in  output  1  to flag register
- zero_in  output  1  to flag register
- carry_wr  output  1  to flag register
- zero_wr  output  1  to flag register

Behaviour:
- Slot contents: two registered slots, MEM and WB. Each holds valid, cwr, zwr, c, z, ldz.
- Reset: all slot fields are 0. carry_wr = zero_wr = 0; carry_in = zero_in = 0. fwd outputs follow arch_* (which are also 0 after reset).
- Advance (stall = 0), per posedge:
  - MEM <= {ex_valid & ~flush, ex_carry_wr, ex_zero_wr, ex_carry, ex_zero, ex_zero_from_load}.
  - WB <= MEM, with z replaced by mem_load_zero when MEM.ldz = 1. WB.valid is cleared if flush = 1.
- stall = 1: both slots hold. Commit outputs are forced to 0, so each WB entry commits exactly once.
- stall and flush together: flush wins. MEM.valid is cleared and WB holds.
- Commit (combinational from WB):
  - carry_wr = WB.valid & WB.cwr & ~stall
  - zero_wr = WB.valid & WB.zwr & ~stall
  - carry_in = WB.c, zero_in = WB.z
  - Flag register updates on the next edge; commit latency is 2 cycles from EX capture.
- Forwarding, per flag independently, priority youngest first:
  1. MEM slot (valid & wr). For zero with MEM.ldz = 1, use mem_load_zero.
  2. WB slot (valid & wr).
  3. arch_*.
  - FWD_EN = 0 selects arch_* always.
- Bubble (ex_valid = 0) enters MEM as invalid. It never commits and never forwards.
- A cwr-only entry does not mask an older zero entry, and vice versa.
- Reset mid-operation clears both slots on the same edge. No commit occurs that cycle, since reset dominates commit gating.
- No wrap-around or arithmetic; all datapaths are 1 bit.

Decomposition:
- Shared package (cpu_pkg): flag_slot_t struct {valid, cwr, zwr, c, z, ldz}; FLAG_C / FLAG_Z index constants.
- One natural sub-module: flag_fwd_mux, the per-flag 3-way priority selector, instantiated twice.

Test Plan:
- Reset, then hold ex_valid = 0 for 5 cycles -> carry_wr = zero_wr = 0 throughout; fwd = arch = 0.
- EX writes c = 1, z = 0 (cycle 0); next EX conditional at cycle 1 -> fwd_carry = 1 at cycle 1; carry_wr = 1, carry_in = 1 at cycle 2; arch_carry = 1 from cycle 3.
- Back-to-back writers c = 1 then c = 0 -> at cycle 2, fwd_carry = 0 (MEM beats WB); commits 1 then 0 in successive cycles.
- Load with ex_zero_from_load = 1, mem_load_zero = 1 -> fwd_zero = 1 while the load is in MEM; zero_in = 1, zero_wr = 1 one cycle later.
- Writer in EX with flush = 1 -> MEM.valid = 0; no commit two cycles later; fwd reverts to arch.
- Writer in WB, stall held 3 cycles -> carry_wr = 0 during the stall; exactly one carry_wr pulse after release; fwd_carry holds the WB value throughout.
